// File: rtl/pipe_stage_reg_if.sv
// Bundle between the hazard unit / upstream stage and a pipe_stage_reg.
// Upstream offers validIn/ctrlIn/dataIn. Each falling edge without stall or flush captures them.
// stall is the only backpressure, and flush discards the offered entry.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic              validIn;
  logic [CTRL_W-1:0] ctrlIn;
  logic [DATA_W-1:0] dataIn;
  logic              valid;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0]  bubbleCount;

  modport master (
    output stall, flush, validIn, ctrlIn, dataIn,
    input  valid, ctrl, data, bubbleCount
  );

  modport slave (
    input  stall, flush, validIn, ctrlIn, dataIn,
    output valid, ctrl, data, bubbleCount
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// DEPTH-stage pipeline register with per-stage valid, stall hold, flush-to-bubble
// and a saturating stall/flush event counter. All state changes on the falling clock edge.
module pipe_stage_reg #(
  parameter int CTRL_W     = 8,
  parameter int DATA_W     = 128,
  parameter int DEPTH      = 1,
  parameter int FLUSH_DATA = 0,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_reg_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              v_q [DEPTH];
  logic [CTRL_W-1:0] c_q [DEPTH];
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q;

  // Control is forced to zero for bubbles, so downstream never sees stray enables.
  always_ff @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        v_q[i] <= 1'b0;
        c_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        v_q[i] <= 1'b0;
        c_q[i] <= '0;
        if (FLUSH_DATA != 0) d_q[i] <= '0;
      end
    end else if (!bus.stall) begin
      v_q[0] <= bus.validIn;
      c_q[0] <= bus.validIn ? bus.ctrlIn : '0;
      d_q[0] <= bus.dataIn;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        c_q[i] <= c_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if ((bus.stall || bus.flush) && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.valid       = v_q[DEPTH-1];
  assign bus.ctrl        = c_q[DEPTH-1];
  assign bus.data        = d_q[DEPTH-1];
  assign bus.bubbleCount = cnt_q;

endmodule
